// File: rtl/upg_pkg.sv
// upg_pkg: shared state type and constants for the UART-programming word loader.
// Defining UPG_CHECKSUM_EN adds the CKSUM state used to wait for the trailing checksum byte.
package upg_pkg;
   localparam int   ADR_W    = 14;
   localparam logic SEL_IMEM = 1'b0;
   localparam logic SEL_DMEM = 1'b1;
`ifdef UPG_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, RECV, DONE, CKSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
`endif
endpackage

// File: rtl/upg_idle_timer.sv
// upg_idle_timer: counts enabled cycles without a clear and flags expiry on the TIMEOUT_CYC-th one.
module upg_idle_timer #(
   parameter int TIMEOUT_CYC = 1000000,
   parameter int TO_W        = 20
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   logic [TO_W-1:0] cnt_q, cnt_d;
   // a clear in the expiring cycle wins, so a late byte is never discarded
   always_comb begin
      expired_o = en_i && !clr_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1));
      cnt_d     = (clr_i || expired_o || !en_i) ? '0 : cnt_q + 1'b1;
   end
   // idle counter register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

// File: rtl/upg_word_loader.sv
// upg_word_loader: packs UART bytes into little-endian words and writes IMEM then DMEM, then raises done.
// Defining UPG_CHECKSUM_EN expects one trailing checksum byte and adds upg_err_o.
module upg_word_loader
   import upg_pkg::*;
#(
   parameter int WORDS       = 16384,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int TO_W        = 20
) (
   input  logic             upg_clk_i,
   input  logic             upg_rst_n_i,
   input  logic [7:0]       rx_dat_i,
   input  logic             rx_vld_i,
   output logic             upg_wen_o,
   output logic             upg_sel_o,
   output logic [ADR_W-1:0] upg_adr_o,
   output logic [31:0]      upg_dat_o,
   output logic             upg_done_o
`ifdef UPG_CHECKSUM_EN
  ,output logic             upg_err_o
`endif
);
`ifdef UPG_CHECKSUM_EN
   localparam state_t FIN = CKSUM;
   logic [7:0] sum_q, sum_d;
   logic       err_q, err_d, cks;
`else
   localparam state_t FIN = DONE;
`endif
   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [23:0]      word_q, word_d;
   logic [31:0]      dat_q, dat_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic             sel_q, sel_d, wen_q, wen_d, done_q, done_d;
   logic             acc, expired, last_adr;

   assign acc      = rx_vld_i && (state_q == IDLE || state_q == RECV);
   assign last_adr = adr_q == ADR_W'(WORDS - 1);

   upg_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) u_timer (
      .clk_i    (upg_clk_i),
      .rst_n_i  (upg_rst_n_i),
      .clr_i    (rx_vld_i),
      .en_i     (state_q == RECV),
      .expired_o(expired)
   );

   // byte capture into lane cnt_q, word completion, timeout discard, address advance after each strobe
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dat_d   = dat_q;
      wen_d   = 1'b0;
      word_d  = {(acc && cnt_q == 2'd2) ? rx_dat_i : word_q[23:16],
                 (acc && cnt_q == 2'd1) ? rx_dat_i : word_q[15:8],
                 (acc && cnt_q == 2'd0) ? rx_dat_i : word_q[7:0]};
      if (acc) begin
         cnt_d   = cnt_q + 2'd1;
         state_d = RECV;
         if (cnt_q == 2'd3) begin
            wen_d   = 1'b1;
            dat_d   = {rx_dat_i, word_q};
            state_d = (last_adr && sel_q == SEL_DMEM) ? FIN : IDLE;
         end
      end else if (expired) begin
         cnt_d   = 2'd0;
         state_d = IDLE;
      end
      adr_d = wen_q ? (last_adr ? '0 : adr_q + 1'b1) : adr_q;
      sel_d = sel_q | (wen_q & last_adr);
`ifdef UPG_CHECKSUM_EN
      cks    = rx_vld_i && state_q == CKSUM;
      sum_d  = acc ? sum_q + rx_dat_i : sum_q;
      err_d  = cks ? (8'(sum_q + rx_dat_i) != 8'd0) : err_q;
      done_d = done_q | cks;
      if (cks) state_d = DONE;
`else
      done_d = done_q | (wen_q & last_adr & sel_q);
`endif
   end

   // state and datapath registers, cleared asynchronously (cancels any strobe in flight)
   always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
      if (!upg_rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         dat_q   <= '0;
         adr_q   <= '0;
         sel_q   <= SEL_IMEM;
         wen_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef UPG_CHECKSUM_EN
         sum_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         dat_q   <= dat_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         wen_q   <= wen_d;
         done_q  <= done_d;
`ifdef UPG_CHECKSUM_EN
         sum_q   <= sum_d;
         err_q   <= err_d;
`endif
      end
   end

   assign upg_wen_o  = wen_q;
   assign upg_sel_o  = sel_q;
   assign upg_adr_o  = adr_q;
   assign upg_dat_o  = dat_q;
   assign upg_done_o = done_q;
`ifdef UPG_CHECKSUM_EN
   assign upg_err_o  = err_q;
`endif
endmodule
